// File: rtl/gcd_engine.sv
`timescale 1ns/1ps
// GCD engine: subtractive Euclid or binary Stein chosen per transaction,
// with valid/ready handshakes on both the operand and the result side.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles,
    output logic             out_err,
    output logic             busy
);
    localparam int KW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        CALC = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt, res;
    logic             mode_q, err_q, k_inc, done_calc;
    logic [KW-1:0]    k_q;
    logic [CNT_W-1:0] cnt_q;

    // One datapath action per CALC cycle; done_calc marks the terminating check.
    always_comb begin
        a_nxt     = a_q;
        b_nxt     = b_q;
        k_inc     = 1'b0;
        done_calc = 1'b0;
        res       = '0;
        if (!mode_q) begin
            if (b_q == '0) begin
                done_calc = 1'b1;
                res       = a_q;
            end else if (a_q < b_q) begin
                a_nxt = b_q;
                b_nxt = a_q;
            end else begin
                a_nxt = a_q - b_q;
            end
        end else begin
            if (a_q == '0) begin
                done_calc = 1'b1;
                res       = b_q << k_q;
            end else if (b_q == '0) begin
                done_calc = 1'b1;
                res       = a_q << k_q;
            end else if (!a_q[0] && !b_q[0]) begin
                a_nxt = a_q >> 1;
                b_nxt = b_q >> 1;
                k_inc = 1'b1;
            end else if (!a_q[0]) begin
                a_nxt = a_q >> 1;
            end else if (!b_q[0]) begin
                b_nxt = b_q >> 1;
            end else if (a_q >= b_q) begin
                a_nxt = (a_q - b_q) >> 1;
            end else begin
                b_nxt = (b_q - a_q) >> 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (abort) state_nxt = IDLE;
                     else if (done_calc) state_nxt = DONE;
            DONE:    if (abort || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state == CALC);
        out_valid = (state == DONE);
    end

    // Result registers only change on the terminating cycle, so they hold
    // through backpressure and keep their last values across an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
            k_q        <= '0;
            cnt_q      <= '0;
            out_gcd    <= '0;
            out_cycles <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    mode_q <= in_mode;
                    err_q  <= (in_a == '0) && (in_b == '0);
                    k_q    <= '0;
                    cnt_q  <= '0;
                end
                CALC: if (!abort) begin
                    if (done_calc) begin
                        out_gcd    <= res;
                        out_cycles <= cnt_q;
                        out_err    <= err_q;
                    end else begin
                        a_q   <= a_nxt;
                        b_q   <= b_nxt;
                        k_q   <= k_q + KW'(k_inc);
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_engine.sv
`timescale 1ns/1ps
// Directed bench for gcd_engine: a negedge monitor checks every cycle against
// an arithmetic model, the driver pins hand-computed literal results.
module tb_gcd_engine;
    localparam int W = 8;
    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_mode = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic          in_ready, out_valid, out_err, busy;
    logic [W-1:0]  out_gcd;
    logic [CW-1:0] out_cycles;

    int total = 0;
    int bad = 0;

    gcd_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_cycles(out_cycles), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // gcd via remainders; update count by walking the algorithm's rules
    function automatic int model_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int model_steps(input int a, input int b, input bit m);
        int n = 0;
        int t;
        if (!m) begin
            while (b != 0) begin
                if (a < b) begin t = a; a = b; b = t; end
                else a = a - b;
                n++;
            end
        end else begin
            while (a != 0 && b != 0) begin
                if (a % 2 == 0 && b % 2 == 0) begin a = a / 2; b = b / 2; end
                else if (a % 2 == 0) a = a / 2;
                else if (b % 2 == 0) b = b / 2;
                else if (a >= b) a = (a - b) / 2;
                else b = (b - a) / 2;
                n++;
            end
        end
        return n;
    endfunction

    bit pending = 1'b0;
    bit seen = 1'b0;
    int edges = 0;
    int m_g = 0, m_c = 0, m_e = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else if (pending) begin
            chk("in_ready_low", in_ready, 0);
            if (out_valid) begin
                if (!seen) begin
                    chk("latency", edges, m_c + 1);
                    seen = 1'b1;
                end
                chk("gcd", out_gcd, m_g);
                chk("cycles", out_cycles, m_c);
                chk("err", out_err, m_e);
                chk("busy_done", busy, 0);
                if (out_ready || abort) pending = 1'b0;
            end else begin
                chk("busy_calc", busy, 1);
                if (abort) pending = 1'b0;
            end
            edges++;
        end else begin
            chk("idle_ready", in_ready, 1);
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
            if (in_valid) begin
                m_g = model_gcd(int'(in_a), int'(in_b));
                m_c = model_steps(int'(in_a), int'(in_b), in_mode);
                m_e = (in_a == 0 && in_b == 0) ? 1 : 0;
                pending = 1'b1;
                seen = 1'b0;
                edges = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int t = 0;
        while (!in_ready && t < 50) begin tick(); t++; end
        chk("ready_wait", in_ready, 1);
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom);
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input int hold, input int eg, input int ec, input int ee);
        int t = 0;
        accept(a, b, m);
        while (!out_valid && t < 1000) begin tick(); t++; end
        chk("lit_valid", out_valid, 1);
        if (!out_valid) return;
        chk("lit_latency", t, ec + 1);
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            in_a = 8'hFF; in_b = 8'h11;
            tick();
            chk("hold_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        chk("lit_gcd", out_gcd, eg);
        chk("lit_cycles", out_cycles, ec);
        chk("lit_err", out_err, ee);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ready_after", in_ready, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_gcd", out_gcd, 0);
        chk("rst_cycles", out_cycles, 0);
        chk("rst_err", out_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        run(8'd12, 8'd8, 1'b0, 0, 4, 5, 0);
        run(8'd12, 8'd8, 1'b1, 0, 4, 5, 0);
        run(8'd48, 8'd18, 1'b1, 0, 6, 6, 0);
        run(8'd48, 8'd18, 1'b0, 0, 6, 8, 0);
        run(8'd0, 8'd0, 1'b0, 0, 0, 0, 1);
        run(8'd0, 8'd7, 1'b0, 0, 7, 1, 0);
        run(8'd9, 8'd0, 1'b0, 0, 9, 0, 0);
        run(8'd9, 8'd0, 1'b1, 0, 9, 0, 0);
        run(8'd255, 8'd1, 1'b0, 0, 1, 256, 0);
        run(8'd255, 8'd1, 1'b1, 0, 1, 8, 0);
        run(8'd12, 8'd8, 1'b0, 10, 4, 5, 0);

        // abort on the third CALC cycle
        accept(8'd200, 8'd3, 1'b0);
        tick();
        tick();
        chk("abort_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        repeat (3) tick();
        run(8'd10, 8'd4, 1'b0, 0, 2, 6, 0);

        // reset during CALC clears the previous result
        accept(8'd255, 8'd1, 1'b0);
        repeat (5) tick();
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_gcd", out_gcd, 0);
        chk("mid_rst_cycles", out_cycles, 0);
        chk("mid_rst_err", out_err, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        run(8'd48, 8'd18, 1'b1, 0, 6, 6, 0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
